// File: rtl/multi_pulse_counter.sv
// multi_pulse_counter: N_BTN debounced pushbuttons with hold-to-repeat, each
// stepping one digit of an N_DIGITS-digit hex or BCD counter up or down.
module multi_pulse_counter #(
    parameter int N_BTN            = 4,
    parameter int N_DIGITS         = 4,
    parameter int CLK_FREQ_HZ      = 12000000,
    parameter int DEBOUNCE_TIME_MS = 10,
    parameter int REPEAT_DELAY_MS  = 500,
    parameter int REPEAT_RATE_MS   = 100,
    parameter int BCD              = 0,
    parameter int SATURATE         = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_BTN-1:0]      btn_in,
    input  logic                  dir_in,
    output logic [4*N_DIGITS-1:0] count_out,
    output logic [N_BTN-1:0]      pressed_out,
    output logic                  overflow_out,
    output logic                  underflow_out
);

    localparam int unsigned CYC_PER_MS = CLK_FREQ_HZ / 1000;
    localparam int unsigned DB_CYC     = CYC_PER_MS * DEBOUNCE_TIME_MS;
    localparam int unsigned DLY_CYC    = CYC_PER_MS * REPEAT_DELAY_MS;
    localparam int unsigned RATE_CYC   = CYC_PER_MS * REPEAT_RATE_MS;
    localparam int unsigned DB_W       = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam int unsigned TMR_MAX    = (DLY_CYC > RATE_CYC) ? DLY_CYC : RATE_CYC;
    localparam int unsigned TMR_W      = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;
    localparam int unsigned BASE       = (BCD != 0) ? 10 : 16;
    localparam logic [3:0]  DMAX       = 4'(BASE - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    logic [N_BTN-1:0]    strobe;
    logic [N_BTN-1:0]    level_vec;
    logic [N_DIGITS-1:0] step;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic            sync1;
        logic            sync2;
        logic            level;
        logic            level_d;
        logic [DB_W-1:0] db_cnt;
        logic            press;
        logic            rpt;

        // Two-flop synchroniser; released (1) out of reset.
        always_ff @(posedge clk) begin
            if (!rst) begin
                sync1 <= 1'b1;
                sync2 <= 1'b1;
            end else begin
                sync1 <= btn_in[i];
                sync2 <= sync1;
            end
        end

        // Debounce: flip the pressed level after DB_CYC consecutive differing samples.
        always_ff @(posedge clk) begin
            if (!rst) begin
                level  <= 1'b0;
                db_cnt <= '0;
            end else if (~sync2 != level) begin
                if (db_cnt == DB_W'(DB_CYC - 1)) begin
                    level  <= ~sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end

        // Delayed level for the press-edge detector.
        always_ff @(posedge clk) begin
            if (!rst) level_d <= 1'b0;
            else      level_d <= level;
        end

        assign press = level & ~level_d;

        if (REPEAT_DELAY_MS > 0) begin : g_rpt
            rpt_state_t       state;
            logic [TMR_W-1:0] tmr;

            // Hold-to-repeat FSM: delay after the press, then fixed-rate strobes.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    state <= RPT_IDLE;
                    tmr   <= '0;
                end else if (!level) begin
                    state <= RPT_IDLE;
                    tmr   <= '0;
                end else begin
                    case (state)
                        RPT_IDLE: begin
                            if (press) begin
                                state <= RPT_DELAY;
                                tmr   <= TMR_W'(DLY_CYC - 1);
                            end
                        end
                        RPT_DELAY, RPT_REPEAT: begin
                            if (tmr == '0) begin
                                state <= RPT_REPEAT;
                                tmr   <= TMR_W'(RATE_CYC - 1);
                            end else begin
                                tmr <= tmr - 1'b1;
                            end
                        end
                        default: begin
                            state <= RPT_IDLE;
                            tmr   <= '0;
                        end
                    endcase
                end
            end

            // Timer expiry while held is the repeat strobe for this cycle.
            assign rpt = level && (state != RPT_IDLE) && (tmr == '0);
        end else begin : g_norpt
            assign rpt = 1'b0;
        end

        assign strobe[i]    = press | rpt;
        assign level_vec[i] = level;
    end

    assign pressed_out = level_vec;
    assign step        = N_DIGITS'(strobe);

    logic [4*N_DIGITS-1:0] next_count;
    logic [4:0]            acc;
    logic                  carry;
    logic                  top_carry;

    // Ripple add/subtract of the strobe vector; each digit sees at most BASE+1.
    always_comb begin
        next_count = count_out;
        acc        = '0;
        carry      = 1'b0;
        for (int unsigned d = 0; d < N_DIGITS; d++) begin
            if (!dir_in) begin
                acc = {1'b0, count_out[4*d +: 4]} + {4'b0, step[d]} + {4'b0, carry};
                if (acc >= 5'(BASE)) begin
                    acc   = acc - 5'(BASE);
                    carry = 1'b1;
                end else begin
                    carry = 1'b0;
                end
            end else begin
                acc = {1'b0, count_out[4*d +: 4]} + 5'(BASE) - {4'b0, step[d]} - {4'b0, carry};
                if (acc >= 5'(BASE)) begin
                    acc   = acc - 5'(BASE);
                    carry = 1'b0;
                end else begin
                    carry = 1'b1;
                end
            end
            next_count[4*d +: 4] = acc[3:0];
        end
        top_carry = carry;
        if (top_carry && (SATURATE != 0)) begin
            next_count = dir_in ? '0 : {N_DIGITS{DMAX}};
        end
    end

    // Counter register and one-cycle limit flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_out     <= '0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
        end else begin
            count_out     <= next_count;
            overflow_out  <= top_carry & ~dir_in;
            underflow_out <= top_carry & dir_in;
        end
    end

endmodule

// File: tb/tb_multi_pulse_counter.sv
// Scoreboard bench: three instances (hex wrap, hex saturate, BCD wrap) share a
// clock; every count/flag event is checked against a queued model result.
module tb_multi_pulse_counter;

    localparam int DB   = 4;
    localparam int DLY  = 10;
    localparam int RATE = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0][3:0]  btn;
    logic [2:0]       dir;
    logic [2:0][15:0] cnt;
    logic [2:0][3:0]  prs;
    logic [2:0]       ovf;
    logic [2:0]       unf;

    always #5 clk = ~clk;

    multi_pulse_counter #(.N_BTN(4), .N_DIGITS(4), .CLK_FREQ_HZ(1000), .DEBOUNCE_TIME_MS(DB),
        .REPEAT_DELAY_MS(DLY), .REPEAT_RATE_MS(RATE), .BCD(0), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .btn_in(btn[0]), .dir_in(dir[0]), .count_out(cnt[0]),
        .pressed_out(prs[0]), .overflow_out(ovf[0]), .underflow_out(unf[0]));

    multi_pulse_counter #(.N_BTN(4), .N_DIGITS(4), .CLK_FREQ_HZ(1000), .DEBOUNCE_TIME_MS(DB),
        .REPEAT_DELAY_MS(DLY), .REPEAT_RATE_MS(RATE), .BCD(0), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .btn_in(btn[1]), .dir_in(dir[1]), .count_out(cnt[1]),
        .pressed_out(prs[1]), .overflow_out(ovf[1]), .underflow_out(unf[1]));

    multi_pulse_counter #(.N_BTN(4), .N_DIGITS(4), .CLK_FREQ_HZ(1000), .DEBOUNCE_TIME_MS(DB),
        .REPEAT_DELAY_MS(DLY), .REPEAT_RATE_MS(RATE), .BCD(1), .SATURATE(0)) u_bcd (
        .clk(clk), .rst(rst), .btn_in(btn[2]), .dir_in(dir[2]), .count_out(cnt[2]),
        .pressed_out(prs[2]), .overflow_out(ovf[2]), .underflow_out(unf[2]));

    typedef struct {
        int          dut;
        logic [17:0] val;  // {overflow, underflow, count}
        int          cyc;
    } ev_t;

    ev_t  exp_q[$];
    int   model[3];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;
    logic [2:0][15:0] prev_cnt;
    ev_t  mon_e;
    logic [17:0] mon_cur;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int v, input int base);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % base);
            t = t / base;
        end
        return r;
    endfunction

    // Integer model of one counter update, queued for the given cycle.
    task automatic expect_step(input int k, input logic [3:0] mask, input logic d, input int at);
        int   base, full, inc, w, nv;
        logic o, u;
        ev_t  e;
        base = (k == 2) ? 10 : 16;
        full = base * base * base * base;
        inc  = 0;
        w    = 1;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) inc += w;
            w *= base;
        end
        o = 1'b0;
        u = 1'b0;
        nv = d ? model[k] - inc : model[k] + inc;
        if (nv >= full) begin
            o  = 1'b1;
            nv = (k == 1) ? full - 1 : nv - full;
        end else if (nv < 0) begin
            u  = 1'b1;
            nv = (k == 1) ? 0 : nv + full;
        end
        model[k] = nv;
        e.dut = k;
        e.val = {o, u, enc(nv, base)};
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    // Press the mask on instance k for h cycles; queue the press and any repeats.
    task automatic hold(input int k, input logic [3:0] mask, input logic d, input int h);
        int c0, u;
        @(posedge clk); #1;
        dir[k] = d;
        btn[k] = ~mask;
        c0 = cyc;
        u  = c0 + 2 + DB + 1;
        expect_step(k, mask, d, u);
        u += DLY;
        while (u <= c0 + h + 2 + DB) begin
            expect_step(k, mask, d, u);
            u += RATE;
        end
        repeat (h) @(posedge clk);
        #1 btn[k] = '1;
        repeat (8) @(posedge clk);
        #1 dir[k] = ~d;
        repeat (4) @(posedge clk);
    endtask

    // Monitor: any count change or flag pulse must match the queue head.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mon_en && (cnt[k] !== prev_cnt[k] || ovf[k] || unf[k])) begin
                mon_cur = {ovf[k], unf[k], cnt[k]};
                if (exp_q.size() == 0) begin
                    check($sformatf("spurious[%0d]", k), {14'd0, mon_cur}, {14'd0, 2'b00, prev_cnt[k]});
                end else begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("dut[%0d]", k), k, mon_e.dut);
                    check($sformatf("value[%0d]", k), {14'd0, mon_cur}, {14'd0, mon_e.val});
                    check($sformatf("cycle[%0d]", k), cyc, mon_e.cyc);
                end
            end
            prev_cnt[k] = cnt[k];
        end
    end

    initial begin
        int c0;
        rst = 1'b0;
        btn = '1;
        dir = '0;
        for (int k = 0; k < 3; k++) model[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_count[%0d]", k), cnt[k], 0);
            check($sformatf("rst_pressed[%0d]", k), prs[k], 0);
            check($sformatf("rst_flags[%0d]", k), {ovf[k], unf[k]}, 0);
        end
        rst = 1'b1;
        mon_en = 1'b1;

        // Clean press: pressed_out at +6, count at +7.
        @(posedge clk); #1;
        btn[0] = 4'b1110;
        c0 = cyc;
        expect_step(0, 4'b0001, 1'b0, c0 + 7);
        repeat (5) @(posedge clk);
        #1;
        check("pressed_early", prs[0], 4'b0000);
        btn[0] = '1;
        @(posedge clk); #1;
        check("pressed_rise", prs[0], 4'b0001);
        check("count_before", cnt[0], 16'h0000);
        @(posedge clk); #1;
        check("count_latency", cnt[0], 16'h0001);
        repeat (12) @(posedge clk);
        hold(0, 4'b0001, 1'b1, 5);

        // Bounce: six 3-cycle low pulses are rejected, then one clean press.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            btn[0][1] = 1'b0;
            repeat (3) @(posedge clk);
            #1 btn[0][1] = 1'b1;
            repeat (2) @(posedge clk);
        end
        hold(0, 4'b0010, 1'b0, 6);
        hold(0, 4'b0010, 1'b1, 5);

        // Hold-to-repeat, then multi-digit ripple and same-cycle strobes.
        hold(0, 4'b0100, 1'b0, 30);
        hold(0, 4'b0100, 1'b0, 30);
        hold(0, 4'b0001, 1'b1, 5);
        hold(0, 4'b0011, 1'b0, 5);
        hold(0, 4'b0011, 1'b1, 5);
        hold(0, 4'b1000, 1'b1, 5);
        hold(0, 4'b0001, 1'b0, 5);
        hold(0, 4'b0001, 1'b1, 5);

        // Saturating instance: clamp at 0 and at 0xFFFF, flags still pulse.
        hold(1, 4'b0001, 1'b1, 5);
        hold(1, 4'b1111, 1'b0, 57);
        hold(1, 4'b0001, 1'b1, 5);

        // BCD instance.
        hold(2, 4'b0111, 1'b0, 33);
        hold(2, 4'b0001, 1'b0, 5);
        hold(2, 4'b1000, 1'b1, 5);
        hold(2, 4'b0001, 1'b1, 5);

        // Reset asserted during auto-repeat clears everything on the next edge.
        @(posedge clk); #1;
        dir[2] = 1'b1;
        btn[2] = 4'b1101;
        c0 = cyc;
        expect_step(2, 4'b0010, 1'b1, c0 + 7);
        expect_step(2, 4'b0010, 1'b1, c0 + 17);
        repeat (18) @(posedge clk);
        #1;
        rst = 1'b0;
        btn[2] = '1;
        for (int k = 0; k < 3; k++) begin
            if (model[k] != 0) begin
                exp_q.push_back('{dut: k, val: 18'd0, cyc: c0 + 19});
                model[k] = 0;
            end
        end
        @(posedge clk); #1;
        check("midrst_count", cnt[2], 16'h0000);
        check("midrst_pressed", prs[2], 4'b0000);
        check("midrst_flags", {ovf[2], unf[2]}, 2'b00);
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
